pc_unit: RTL and testbench
==========================

# pc_unit

Program counter for the gate-level CPU datapath, one stage downstream of the combinational gate primitives (not/and/or/xor/mux/dmux). Holds the current instruction address and each clock either clears, loads, increments or holds it. It also performs call/return through a small hardware return-address stack (RAS). Feeds instruction memory address and the ALU's PC-relative operand.

## Interface
- WIDTH, 16, PC and data width in bits (≥4).
- RESET_VECTOR, 0, PC value after reset or clear.
- DEPTH, 4, RAS entries (power of two, 2–16).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear to RESET_VECTOR, empties RAS, clears ras_err.
- load  input  1  pc <= d.
- inc  input  1  pc <= pc + 1.
- d  input  WIDTH  jump/call target.
- call  input  1  push pc+1, pc <= d.
- ret  input  1  pop top of RAS into pc.
- pc  output  WIDTH  current address, registered.
- ras_empty  output  1  RAS holds 0 entries, registered.
- ras_full  output  1  RAS holds DEPTH entries, registered.
- ras_err  output  1  sticky overflow/underflow flag, registered.

## Operation
- Reset (rst_n low, async): pc = RESET_VECTOR, RAS count = 0, ras_empty = 1, ras_full = 0, ras_err = 0. Held while rst_n low; release takes effect at the next clk edge.
- One command is taken per edge, in strict priority: clr > call > ret > load > inc > hold. Lower-priority requests in the same cycle are ignored with no side effect.
- call: RAS push of (pc + 1) mod 2^WIDTH; pc <= d. When full, the oldest entry is overwritten (circular buffer), count stays DEPTH, ras_err <= 1.
- ret: non-empty: pc <= top, count decrements. Empty: pc holds, count stays 0, ras_err <= 1.
- call and ret together: call executes, ret dropped, no error.
- load: pc <= d. inc: pc <= pc + 1, wraps from all-ones to 0 silently.
- RAS state: write pointer plus count (0..DEPTH). ras_empty = (count == 0), ras_full = (count == DEPTH).
- ras_err is cleared only by reset or clr.
- Arithmetic: all additions are modulo 2^WIDTH, no carry out.

## Timing
- All outputs registered, with no combinational input-to-output path.
- Latency 1: a command sampled at edge N is visible on pc/flags after edge N.
- Back-to-back calls/rets are allowed every cycle. call at N then ret at N+1 returns pc to (pc before N) + 1 after edge N+1.
- Async reset asserted mid-command aborts it. No partial RAS update survives.
- d is sampled only on load/call edges.

## Configuration
- PC_UNIT_RAS_EN defined: RAS, call/ret behaviour and flags as above.
- Not defined: no RAS storage. call behaves exactly as load (pc <= d). ret is ignored (hold). ras_empty tied 1, ras_full tied 0, ras_err tied 0. Ports remain present.

## Test plan
- Reset then inc x3 with RESET_VECTOR=0x0100 -> pc 0x0100, 0x0101, 0x0102, 0x0103; ras_empty=1.
- pc=0xFFFF, inc -> pc=0x0000, ras_err=0. load d=0x1234 with inc also high -> pc=0x1234.
- From pc=0x0010: call d=0x0200, call d=0x0300, ret, ret -> pc 0x0200, 0x0300, 0x0201, 0x0011; ras_empty=1 at end, ras_err=0.
- DEPTH=4: 5 calls from pc=0x0000 with d=0x0010,0x0020,0x0030,0x0040,0x0050 -> ras_full=1, ras_err=1. 4 rets -> pc 0x0041, 0x0031, 0x0021, 0x0011. A 5th ret leaves pc at 0x0011 with ras_err still 1. clr -> pc=RESET_VECTOR, ras_err=0.
- call+ret+load+clr all high -> clr wins. call+ret -> push occurs, pc=d. rst_n pulsed low mid-cycle after a call -> pc=RESET_VECTOR immediately, ras_empty=1.
- Build without PC_UNIT_RAS_EN: call d=0x0400 -> pc=0x0400. ret -> pc holds 0x0400. Flags constant 1/0/0.

Source files
------------

// File: rtl/pc_unit_if.sv
// Command/status bundle between the sequencer and the program counter.
// master drives the per-cycle commands and target; slave returns pc and RAS flags.
interface pc_unit_if #(
    parameter int WIDTH = 16
);
    logic             clr;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] pc;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    modport master (
        output clr, load, inc, call, ret, d,
        input  pc, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  clr, load, inc, call, ret, d,
        output pc, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with clear/load/increment and call/return through a circular
// return-address stack. The RAS exists only when PC_UNIT_RAS_EN is defined.
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               DEPTH        = 4
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_LOAD,
        CMD_RET,
        CMD_CALL,
        CMD_CLR
    } cmd_e;

    if (WIDTH < 4) begin : g_bad_width
        $error("pc_unit: WIDTH must be at least 4");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_unit: DEPTH must be a power of two in 2..16");
    end

    cmd_e             cmd;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ret_target;

    // Only the highest-priority request is acted on; the rest are dropped.
    always_comb begin
        cmd = CMD_HOLD;
        if (bus.clr)       cmd = CMD_CLR;
        else if (bus.call) cmd = CMD_CALL;
        else if (bus.ret)  cmd = CMD_RET;
        else if (bus.load) cmd = CMD_LOAD;
        else if (bus.inc)  cmd = CMD_INC;
    end

    assign pc_inc = pc_q + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            unique case (cmd)
                CMD_CLR:            pc_q <= RESET_VECTOR;
                CMD_CALL, CMD_LOAD: pc_q <= bus.d;
                CMD_RET:            pc_q <= ret_target;
                CMD_INC:            pc_q <= pc_inc;
                default:            pc_q <= pc_q;
            endcase
        end
    end

    assign bus.pc = pc_q;

`ifdef PC_UNIT_RAS_EN
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] ras_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             ras_empty_q;
    logic             ras_full_q;
    logic             ras_err_q;

    assign rd_ptr     = wr_ptr - PTR_W'(1);
    assign ret_target = (count != '0) ? ras_mem[rd_ptr] : pc_q;

    // A push onto a full stack overwrites the oldest entry, so count saturates.
    always_comb begin
        count_nxt = count;
        unique case (cmd)
            CMD_CLR:  count_nxt = '0;
            CMD_CALL: if (count != FULL_CNT) count_nxt = count + (PTR_W + 1)'(1);
            CMD_RET:  if (count != '0)       count_nxt = count - (PTR_W + 1)'(1);
            default:  count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            count       <= '0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            ras_err_q   <= 1'b0;
        end else begin
            count       <= count_nxt;
            ras_empty_q <= (count_nxt == '0);
            ras_full_q  <= (count_nxt == FULL_CNT);
            unique case (cmd)
                CMD_CLR: begin
                    wr_ptr    <= '0;
                    ras_err_q <= 1'b0;
                end
                CMD_CALL: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (count == FULL_CNT) ras_err_q <= 1'b1;
                end
                CMD_RET: begin
                    if (count != '0) wr_ptr    <= rd_ptr;
                    else             ras_err_q <= 1'b1;
                end
                default: wr_ptr <= wr_ptr;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (rst_n && cmd == CMD_CALL) ras_mem[wr_ptr] <= pc_inc;
    end

    assign bus.ras_empty = ras_empty_q;
    assign bus.ras_full  = ras_full_q;
    assign bus.ras_err   = ras_err_q;
`else
    assign ret_target    = pc_q;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, mid-cycle reset sequence and a
// randomized run against a queue-based model of the return-address stack.
module tb_pc_unit;
    localparam int          WIDTH = 16;
    localparam logic [15:0] RV    = 16'h0100;
    localparam int          DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_CLR  = 5'b10000;
    localparam logic [4:0] C_CALL = 5'b01000;
    localparam logic [4:0] C_RET  = 5'b00100;
    localparam logic [4:0] C_LOAD = 5'b00010;
    localparam logic [4:0] C_INC  = 5'b00001;

    typedef struct {
        logic [4:0]  ctrl;
        logic [15:0] d;
        logic [15:0] pc;
        logic        e;
        logic        f;
        logic        r;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    logic [15:0] pc_m;
    logic [15:0] ras_q[$];
    logic        err_m;

    pc_unit_if #(.WIDTH(WIDTH)) bus ();

    pc_unit #(
        .WIDTH(WIDTH),
        .RESET_VECTOR(RV),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [4:0] c, input logic [15:0] dv, input logic [15:0] ep,
                       input logic e, input logic f, input logic r);
        vec_t v;
        v.ctrl = c; v.d = dv; v.pc = ep; v.e = e; v.f = f; v.r = r;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] c, input logic [15:0] dv);
        bus.clr  = c[4];
        bus.call = c[3];
        bus.ret  = c[2];
        bus.load = c[1];
        bus.inc  = c[0];
        bus.d    = dv;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic [15:0] ep,
                           input logic e, input logic f, input logic r);
        chk({nm, ".pc"}, idx, bus.pc, ep);
        chk({nm, ".empty"}, idx, 16'(bus.ras_empty), 16'(e));
        chk({nm, ".full"}, idx, 16'(bus.ras_full), 16'(f));
        chk({nm, ".err"}, idx, 16'(bus.ras_err), 16'(r));
    endtask

    task automatic model_reset();
        pc_m = RV;
        ras_q.delete();
        err_m = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] c, input logic [15:0] dv);
        if (c[4]) begin
            model_reset();
        end else if (c[3]) begin
            if (RAS_EN) begin
                if (ras_q.size() == DEPTH) begin
                    void'(ras_q.pop_front());
                    err_m = 1'b1;
                end
                ras_q.push_back(pc_m + 16'd1);
            end
            pc_m = dv;
        end else if (c[2]) begin
            if (RAS_EN) begin
                if (ras_q.size() > 0) pc_m = ras_q.pop_back();
                else                  err_m = 1'b1;
            end
        end else if (c[1]) begin
            pc_m = dv;
        end else if (c[0]) begin
            pc_m = pc_m + 16'd1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(C_NONE, 16'h0);

`ifdef PC_UNIT_RAS_EN
        add(C_INC,  16'h0000, 16'h0101, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0102, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0103, 1, 0, 0);
        add(C_LOAD, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0000, 1, 0, 0);
        add(C_LOAD | C_INC, 16'h1234, 16'h1234, 1, 0, 0);
        add(C_LOAD, 16'h0010, 16'h0010, 1, 0, 0);
        add(C_CALL, 16'h0200, 16'h0200, 0, 0, 0);
        add(C_CALL, 16'h0300, 16'h0300, 0, 0, 0);
        add(C_RET,  16'h0000, 16'h0201, 0, 0, 0);
        add(C_RET,  16'h0000, 16'h0011, 1, 0, 0);
        add(C_LOAD, 16'h0000, 16'h0000, 1, 0, 0);
        add(C_CALL, 16'h0010, 16'h0010, 0, 0, 0);
        add(C_CALL, 16'h0020, 16'h0020, 0, 0, 0);
        add(C_CALL, 16'h0030, 16'h0030, 0, 0, 0);
        add(C_CALL, 16'h0040, 16'h0040, 0, 1, 0);
        add(C_CALL, 16'h0050, 16'h0050, 0, 1, 1);
        add(C_RET,  16'h0000, 16'h0041, 0, 0, 1);
        add(C_RET,  16'h0000, 16'h0031, 0, 0, 1);
        add(C_RET,  16'h0000, 16'h0021, 0, 0, 1);
        add(C_RET,  16'h0000, 16'h0011, 1, 0, 1);
        add(C_RET,  16'h0000, 16'h0011, 1, 0, 1);
        add(C_CLR,  16'h0000, 16'h0100, 1, 0, 0);
        add(5'b11111, 16'h5555, 16'h0100, 1, 0, 0);
        add(C_LOAD, 16'h0007, 16'h0007, 1, 0, 0);
        add(C_CALL | C_RET, 16'h0600, 16'h0600, 0, 0, 0);
        add(C_RET | C_LOAD | C_INC, 16'h1111, 16'h0008, 1, 0, 0);
        add(C_RET,  16'h0000, 16'h0008, 1, 0, 1);
        add(C_CLR,  16'h0000, 16'h0100, 1, 0, 0);
`else
        add(C_INC,  16'h0000, 16'h0101, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0102, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0103, 1, 0, 0);
        add(C_LOAD, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        add(C_INC,  16'h0000, 16'h0000, 1, 0, 0);
        add(C_LOAD | C_INC, 16'h1234, 16'h1234, 1, 0, 0);
        add(C_LOAD, 16'h0010, 16'h0010, 1, 0, 0);
        add(C_CALL, 16'h0400, 16'h0400, 1, 0, 0);
        add(C_RET,  16'h0000, 16'h0400, 1, 0, 0);
        add(C_CALL, 16'h0300, 16'h0300, 1, 0, 0);
        add(C_RET,  16'h0000, 16'h0300, 1, 0, 0);
        add(C_CALL, 16'h0050, 16'h0050, 1, 0, 0);
        add(C_RET,  16'h0000, 16'h0050, 1, 0, 0);
        add(C_CLR,  16'h0000, 16'h0100, 1, 0, 0);
        add(5'b11111, 16'h5555, 16'h0100, 1, 0, 0);
        add(C_LOAD, 16'h0007, 16'h0007, 1, 0, 0);
        add(C_CALL | C_RET, 16'h0600, 16'h0600, 1, 0, 0);
        add(C_CLR,  16'h0000, 16'h0100, 1, 0, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, RV, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("reset_rel", 0, RV, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ctrl, vecs[i].d);
            @(posedge clk);
            #1;
            chk_all("vec", i, vecs[i].pc, vecs[i].e, vecs[i].f, vecs[i].r);
        end

        // Async reset in the middle of a cycle, right after a call.
        drive(C_CALL, 16'h0800);
        @(posedge clk);
        #1;
        chk_all("mid_call", 0, 16'h0800, !RAS_EN, 1'b0, 1'b0);
        drive(C_NONE, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, RV, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_RET, 16'h0000);
        @(posedge clk);
        #1;
        chk_all("post_rst_ret", 0, RV, 1'b1, 1'b0, RAS_EN);

        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  c;
            logic [15:0] dv;
            c    = C_NONE;
            c[4] = ($urandom_range(0, 31) == 0);
            c[3] = ($urandom_range(0, 3) == 0);
            c[2] = ($urandom_range(0, 3) == 0);
            c[1] = ($urandom_range(0, 5) == 0);
            c[0] = ($urandom_range(0, 1) == 0);
            if (!RAS_EN && c[2]) c[1:0] = 2'b00;
            dv = 16'($urandom);
            model_step(c, dv);
            drive(c, dv);
            @(posedge clk);
            #1;
            chk_all("rand", i, pc_m,
                    RAS_EN ? (ras_q.size() == 0) : 1'b1,
                    RAS_EN ? (ras_q.size() == DEPTH) : 1'b0,
                    RAS_EN ? err_m : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
